pll_lock_sequencer: RTL
=======================

// Module: pll_lock_sequencer
// PURPOSE
//  Sequences the UART baud-clock PLL, which runs from a 50 MHz refclk and produces a 1.843198 MHz outclk.
//  - Drives the PLL reset and watches its asynchronous locked flag.
//  - Holds the UART logic in reset until lock has been stable for a set time.
//  - Re-sequences on loss of lock and retries a bounded number of times before declaring a fault.
//  - Sits between the top level and the PLL wrapper, in the refclk domain.
// PARAMETERS
//  RST_PULSE_CYCLES    16     refclk cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT_CYCLES 50000  cycles to wait for lock per attempt (1 ms at 50 MHz)
//  LOCK_STABLE_CYCLES  1024   consecutive locked cycles required before release
//  MAX_RETRIES         4      failed attempts allowed before FAULT (>=1)
// PORTS
//  refclk       in   1  50 MHz reference clock; all logic in this domain
//  rst_n        in   1  asynchronous active-low reset
//  pll_locked   in   1  PLL locked flag, asynchronous; 2-flop synchronised internally
//  restart      in   1  1-cycle request to restart the sequence from any state
//  pll_rst      out  1  PLL reset, active high
//  uart_rst_n   out  1  UART reset, active low; consumer resynchronises it into the outclk domain
//  fault        out  1  high while in FAULT
//  state        out  3  current state: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4
//  retry_cnt    out  $clog2(MAX_RETRIES+1)  failed attempts since last RUN or restart
//  loss_cnt     out  8  lock losses seen in RUN, saturates at 255
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: state=RESET, pll_rst=1, uart_rst_n=0, fault=0, retry_cnt=0, loss_cnt=0, sync flops=0.
//  - Reset is asserted asynchronously and released synchronously to refclk.
//  - lk = pll_locked after the 2-flop synchroniser; lk lags pll_locked by 2 cycles.
//  - pll_rst=1 only in RESET and FAULT; uart_rst_n=1 only in RUN.
//  - RESET: pll_rst stays high for exactly RST_PULSE_CYCLES cycles, then the block enters WAIT_LOCK.
//  - WAIT_LOCK: the timer restarts on entry.
//    - lk=1: go to STABLE.
//    - LOCK_TIMEOUT_CYCLES elapse with lk=0: count one failure (see failure rule).
//    - lk=1 in the timeout cycle: lock wins.
//  - STABLE: the counter restarts on entry.
//    - LOCK_STABLE_CYCLES consecutive cycles of lk=1: go to RUN; retry_cnt clears on entry.
//    - Any lk=0: count one failure.
//  - RUN: lock loss (see macro) -> loss_cnt+1 (saturating) and go to RESET.
//    - uart_rst_n falls in the same clock edge as the state change.
//  - Failure rule:
//    - retry_cnt+1 == MAX_RETRIES -> go to FAULT with retry_cnt=MAX_RETRIES.
//    - Otherwise -> retry_cnt+1 and go to RESET.
//  - FAULT: pll_rst=1 and fault=1; the block stays in FAULT until restart or rst_n.
//  - restart has top priority in every state:
//    - Next state is RESET; retry_cnt clears; all timers clear.
//    - restart in RUN does not increment loss_cnt.
//    - restart arriving in the same cycle as a lock loss or timeout: restart wins.
//  - Timers are sized with $clog2 of the corresponding parameter and never wrap; they hold at their terminal value.
//  - rst_n asserted mid-sequence returns all outputs to reset values immediately (asynchronous).
// CONFIGURATION
//  PLL_SEQ_LOSS_FILTER_EN
//   - Defined: a RUN lock loss requires lk=0 for 4 consecutive cycles.
//     - Shorter glitches are ignored and do not count toward loss_cnt.
//     - uart_rst_n falls on the edge after the 4th low cycle.
//   - Undefined: a single cycle of lk=0 in RUN is a lock loss.
//   - The filter applies to RUN only; STABLE always uses the single-cycle rule.
// TESTING
//  Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
//  1. rst_n released; pll_locked rises 3 cycles after pll_rst falls.
//     -> pll_rst high exactly 4 cycles.
//     -> state 0->1->2->3.
//     -> uart_rst_n rises 8 cycles after lk rises.
//     -> retry_cnt=0, fault=0.
//  2. pll_locked held 0.
//     -> timeout after 20 cycles; retry_cnt=1; second pll_rst pulse.
//     -> second timeout -> FAULT: fault=1, pll_rst=1, retry_cnt=2.
//     -> restart pulse -> state=0, retry_cnt=0, fault=0.
//  3. In RUN, pll_locked low for 1 cycle.
//     -> without macro: loss_cnt=1, uart_rst_n=0, state=0.
//     -> with PLL_SEQ_LOSS_FILTER_EN: no change.
//     -> with macro, 4-cycle drop: loss_cnt=1.
//  4. In STABLE, lk drops at count 5.
//     -> retry_cnt=1, state=0, uart_rst_n stays 0.
//  5. restart coincident with RUN lock loss.
//     -> state=0, loss_cnt unchanged.
//     -> Also, lock and timeout in the same cycle -> STABLE.
//  6. rst_n asserted during STABLE.
//     -> pll_rst=1, uart_rst_n=0 and counters 0 asynchronously.
//     -> 256 RUN losses -> loss_cnt saturates at 255.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//
// Brings up the UART baud-clock PLL (50 MHz refclk -> 1.843198 MHz outclk).
// It pulses the PLL reset, waits for the PLL to lock, and requires the lock to
// hold for a while before it releases the UART reset. When lock is lost in
// RUN, the sequence starts again. Failed attempts are counted, and after
// MAX_RETRIES failures the block parks in FAULT until it sees restart or
// rst_n. All logic runs in the refclk domain.
//
// Ports
//   refclk      in   50 MHz reference clock
//   rst_n       in   asynchronous active-low reset, released synchronously
//   pll_locked  in   PLL locked flag (asynchronous, 2-flop synchronised here)
//   restart     in   1-cycle request to restart the sequence from any state
//   pll_rst     out  PLL reset, active high (RESET and FAULT only)
//   uart_rst_n  out  UART reset, active low (released in RUN only)
//   fault       out  high while in FAULT
//   state       out  RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4
//   retry_cnt   out  failed attempts since the last RUN entry or restart
//   loss_cnt    out  RUN lock losses, saturating at 255
//
// Configuration
//   PLL_SEQ_LOSS_FILTER_EN  when defined, a lock loss in RUN is recognised
//                           only after 4 consecutive low cycles of the
//                           synchronised lock flag. When undefined, a single
//                           low cycle is enough.
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 4
) (
    input  logic                             refclk,
    input  logic                             rst_n,
    input  logic                             pll_locked,
    input  logic                             restart,
    output logic                             pll_rst,
    output logic                             uart_rst_n,
    output logic                             fault,
    output logic [2:0]                       state,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
    output logic [7:0]                       loss_cnt
);

    // Each timer counts 0..N-1, so $clog2(N) bits are enough. A 1-bit minimum
    // covers N=1.
    localparam int unsigned RPW = (RST_PULSE_CYCLES    > 1) ? $clog2(RST_PULSE_CYCLES)    : 1;
    localparam int unsigned TOW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
    localparam int unsigned STW = (LOCK_STABLE_CYCLES  > 1) ? $clog2(LOCK_STABLE_CYCLES)  : 1;
    localparam int unsigned RW  = $clog2(MAX_RETRIES + 1);

    localparam logic [RPW-1:0] RP_LAST    = RPW'(RST_PULSE_CYCLES - 1);
    localparam logic [TOW-1:0] TO_LAST    = TOW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [STW-1:0] ST_LAST    = STW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0]  RETRY_LAST = RW'(MAX_RETRIES - 1);
    localparam logic [RW-1:0]  RETRY_MAX  = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    // Lock-flag synchroniser
    logic sync1_q, sync2_q;
    logic lk;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
        end
    end

    assign lk = sync2_q;

    // Sequencer state and registered outputs
    state_e           state_q,      state_d;
    logic             pll_rst_q,    pll_rst_d;
    logic             uart_rst_n_q, uart_rst_n_d;
    logic             fault_q,      fault_d;
    logic [RW-1:0]    retry_q,      retry_d;
    logic [7:0]       loss_q,       loss_d;
    logic [RPW-1:0]   rst_tmr_q,    rst_tmr_d;
    logic [TOW-1:0]   to_tmr_q,     to_tmr_d;
    logic [STW-1:0]   stb_tmr_q,    stb_tmr_d;
`ifdef PLL_SEQ_LOSS_FILTER_EN
    logic [1:0]       flt_q,        flt_d;
`endif

    logic fail;      // the current attempt failed (timeout or early drop)
    logic loss_evt;  // lock loss recognised in RUN

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        loss_d    = loss_q;
        rst_tmr_d = rst_tmr_q;
        to_tmr_d  = to_tmr_q;
        stb_tmr_d = stb_tmr_q;
`ifdef PLL_SEQ_LOSS_FILTER_EN
        flt_d     = flt_q;
`endif
        fail      = 1'b0;
        loss_evt  = 1'b0;

        if (restart) begin
            // restart overrides any event that happens in the same cycle
            state_d   = ST_RESET;
            retry_d   = '0;
            rst_tmr_d = '0;
            to_tmr_d  = '0;
            stb_tmr_d = '0;
`ifdef PLL_SEQ_LOSS_FILTER_EN
            flt_d     = '0;
`endif
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (rst_tmr_q == RP_LAST) begin
                        state_d  = ST_WAIT_LOCK;
                        to_tmr_d = '0;
                    end else begin
                        rst_tmr_d = rst_tmr_q + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    // Lock takes priority over a timeout in the same cycle
                    if (lk) begin
                        state_d   = ST_STABLE;
                        stb_tmr_d = '0;
                    end else if (to_tmr_q == TO_LAST) begin
                        fail = 1'b1;
                    end else begin
                        to_tmr_d = to_tmr_q + 1'b1;
                    end
                end

                ST_STABLE: begin
                    if (!lk) begin
                        fail = 1'b1;
                    end else if (stb_tmr_q == ST_LAST) begin
                        state_d = ST_RUN;
                        retry_d = '0;
`ifdef PLL_SEQ_LOSS_FILTER_EN
                        flt_d   = '0;
`endif
                    end else begin
                        stb_tmr_d = stb_tmr_q + 1'b1;
                    end
                end

                ST_RUN: begin
`ifdef PLL_SEQ_LOSS_FILTER_EN
                    // Counts consecutive low cycles. The fourth one is a loss.
                    if (lk) begin
                        flt_d = '0;
                    end else if (flt_q == 2'd3) begin
                        loss_evt = 1'b1;
                    end else begin
                        flt_d = flt_q + 1'b1;
                    end
`else
                    loss_evt = !lk;
`endif
                    if (loss_evt) begin
                        state_d   = ST_RESET;
                        rst_tmr_d = '0;
                        if (loss_q != 8'hFF) begin
                            loss_d = loss_q + 1'b1;
                        end
`ifdef PLL_SEQ_LOSS_FILTER_EN
                        flt_d = '0;
`endif
                    end
                end

                ST_FAULT: begin
                    state_d = ST_FAULT;
                end

                default: begin
                    state_d   = ST_RESET;
                    rst_tmr_d = '0;
                end
            endcase

            if (fail) begin
                if (retry_q == RETRY_LAST) begin
                    state_d = ST_FAULT;
                    retry_d = RETRY_MAX;
                end else begin
                    state_d   = ST_RESET;
                    retry_d   = retry_q + 1'b1;
                    rst_tmr_d = '0;
                end
            end
        end

        // Outputs are decoded from the next state and then registered, so
        // each output changes on the same edge as the state.
        pll_rst_d    = (state_d == ST_RESET) || (state_d == ST_FAULT);
        uart_rst_n_d = (state_d == ST_RUN);
        fault_d      = (state_d == ST_FAULT);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RESET;
            pll_rst_q    <= 1'b1;
            uart_rst_n_q <= 1'b0;
            fault_q      <= 1'b0;
            retry_q      <= '0;
            loss_q       <= '0;
            rst_tmr_q    <= '0;
            to_tmr_q     <= '0;
            stb_tmr_q    <= '0;
`ifdef PLL_SEQ_LOSS_FILTER_EN
            flt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pll_rst_q    <= pll_rst_d;
            uart_rst_n_q <= uart_rst_n_d;
            fault_q      <= fault_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            rst_tmr_q    <= rst_tmr_d;
            to_tmr_q     <= to_tmr_d;
            stb_tmr_q    <= stb_tmr_d;
`ifdef PLL_SEQ_LOSS_FILTER_EN
            flt_q        <= flt_d;
`endif
        end
    end

    assign state      = state_q;
    assign pll_rst    = pll_rst_q;
    assign uart_rst_n = uart_rst_n_q;
    assign fault      = fault_q;
    assign retry_cnt  = retry_q;
    assign loss_cnt   = loss_q;

endmodule
